// File: rtl/imem_program_loader.sv
// Loads a program image from a UART byte stream into instruction memory,
// packing bytes MSB-first into 32-bit words while holding the CPU halted.
module imem_program_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                state;
    logic [1:0]            idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           word;
    logic [ADDR_WIDTH:0]   wcnt;
    logic [TW-1:0]         tcnt;
    logic                  flush;

    // All outputs decode from state/registers only, never from rx_valid or start.
    assign rx_ready   = (state == LOAD);
    assign imem_we    = (state == WRITE);
    assign cpu_hold   = (state != IDLE);
    assign done       = (state == DONE);
    assign imem_addr  = addr;
    assign imem_wdata = word;
    assign word_count = wcnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            addr  <= '0;
            word  <= '0;
            wcnt  <= '0;
            tcnt  <= '0;
            flush <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        idx   <= '0;
                        addr  <= '0;
                        word  <= '0;
                        wcnt  <= '0;
                        tcnt  <= '0;
                        flush <= 1'b0;
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        // ~idx == 3-idx: byte 0 lands in bits [31:24].
                        word[{~idx, 3'b000} +: 8] <= rx_data;
                        idx  <= idx + 2'd1;
                        tcnt <= '0;
                        if (idx == 2'd3)
                            state <= WRITE;
                    end else if (tcnt == T_LAST) begin
                        tcnt <= '0;
                        // Unreceived low bytes are already zero: the word
                        // register is cleared on start and after every write.
                        if (idx != 2'd0) begin
                            flush <= 1'b1;
                            state <= WRITE;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WRITE: begin
                    wcnt <= wcnt + 1'b1;
                    addr <= addr + 1'b1;
                    word <= '0;
                    idx  <= '0;
                    tcnt <= '0;
                    if (flush || (addr == {ADDR_WIDTH{1'b1}}))
                        state <= DONE;
                    else
                        state <= LOAD;
                end
                DONE: begin
                    flush <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: a 14-bit-address instance for
// the main scenarios and a 2-bit-address instance for the memory-full case.
module tb_imem_program_loader;

    localparam int AW = 14;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    start, rx_valid, rx_ready, imem_we, cpu_hold, done;
    logic [7:0]    rx_data [2];
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic [1:0]    s_addr;
    logic [31:0]   s_wdata;
    logic [2:0]    s_wcount;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t sb0[$];
    wr_t sb1[$];

    imem_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .rx_valid(rx_valid[0]),
        .rx_data(rx_data[0]), .rx_ready(rx_ready[0]), .imem_we(imem_we[0]),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold[0]),
        .done(done[0]), .word_count(word_count)
    );

    imem_program_loader #(.ADDR_WIDTH(2), .TIMEOUT_CYCLES(T)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .rx_valid(rx_valid[1]),
        .rx_data(rx_data[1]), .rx_ready(rx_ready[1]), .imem_we(imem_we[1]),
        .imem_addr(s_addr), .imem_wdata(s_wdata), .cpu_hold(cpu_hold[1]),
        .done(done[1]), .word_count(s_wcount)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every write cycle must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e0;
        if (rst_n && imem_we[0]) begin
            check("ready_in_write", rx_ready[0], 1'b0);
            if (sb0.size() == 0) begin
                check("unexpected_write", sb0.size(), 1);
            end else begin
                e0 = sb0.pop_front();
                check("waddr", imem_addr, e0.addr);
                check("wdata", imem_wdata, e0.data);
            end
        end
    end

    always @(negedge clk) begin
        wr_t e1;
        if (rst_n && imem_we[1]) begin
            if (sb1.size() == 0) begin
                check("small_unexpected_write", sb1.size(), 1);
            end else begin
                e1 = sb1.pop_front();
                check("small_waddr", s_addr, e1.addr);
                check("small_wdata", s_wdata, e1.data);
            end
        end
    end

    task automatic expect_wr(input int u, input int a, input logic [31:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        if (u == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
    endtask

    task automatic send_byte(input int u, input logic [7:0] b);
        rx_valid[u] = 1'b1;
        rx_data[u]  = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rx_ready[u]) begin
                @(posedge clk);
                #1;
                rx_valid[u] = 1'b0;
                return;
            end
        end
        rx_valid[u] = 1'b0;
        check("send_timeout", rx_ready[u], 1'b1);
    endtask

    // Counts negedges from now until done; n=0 is the current cycle.
    task automatic finish_load(input int u, input int exp_n, input int exp_wc);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (done[u]) break;
            n++;
        end
        check("done_latency", n, exp_n);
        check("word_count", (u == 0) ? word_count : (AW+1)'(s_wcount), exp_wc);
        check("hold_at_done", cpu_hold[u], 1'b1);
        @(negedge clk);
        check("hold_after_done", cpu_hold[u], 1'b0);
        check("done_pulse", done[u], 1'b0);
    endtask

    initial begin
        logic [7:0] t1 [8];
        logic [7:0] t2 [6];
        int ready_seen;

        t1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h09, 8'h50, 8'h20};
        t2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        start = '0;
        rx_valid = '0;
        rx_data[0] = '0;
        rx_data[1] = '0;

        #12;
        check("reset_outputs", {rx_ready[0], imem_we[0], imem_addr, imem_wdata,
                                cpu_hold[0], done[0], word_count}, 0);
        check("reset_small", {rx_ready[1], imem_we[1], s_addr, s_wdata,
                              cpu_hold[1], done[1], s_wcount}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two full words, then timeout.
        pulse_start(0);
        check("ready_after_start", rx_ready[0], 1'b1);
        check("hold_after_start", cpu_hold[0], 1'b1);
        expect_wr(0, 0, 32'h20080005);
        expect_wr(0, 1, 32'h00095020);
        foreach (t1[i]) send_byte(0, t1[i]);
        finish_load(0, 17, 2);

        // Partial last word, zero-filled.
        pulse_start(0);
        expect_wr(0, 0, 32'hAABBCCDD);
        expect_wr(0, 1, 32'h11220000);
        foreach (t2[i]) send_byte(0, t2[i]);
        finish_load(0, 17, 2);

        // Empty load.
        pulse_start(0);
        finish_load(0, 16, 0);

        // Byte held across WRITE; start during LOAD ignored.
        pulse_start(0);
        expect_wr(0, 0, 32'h01020304);
        expect_wr(0, 1, 32'h05060708);
        for (int i = 1; i <= 5; i++) send_byte(0, 8'(i));
        pulse_start(0);
        for (int i = 6; i <= 8; i++) send_byte(0, 8'(i));
        finish_load(0, 17, 2);

        // Reset mid-word discards the partial word.
        pulse_start(0);
        expect_wr(0, 0, 32'hA1A2A3A4);
        for (int i = 1; i <= 7; i++) send_byte(0, 8'hA0 + 8'(i));
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_load", {rx_ready[0], imem_we[0], imem_addr, imem_wdata,
                                 cpu_hold[0], done[0], word_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(0);
        expect_wr(0, 0, 32'hB1B2B3B4);
        for (int i = 1; i <= 4; i++) send_byte(0, 8'hB0 + 8'(i));
        finish_load(0, 17, 1);

        // Memory full on the 2-bit instance: 16 of 20 bytes consumed.
        pulse_start(1);
        for (int w = 0; w < 4; w++)
            expect_wr(1, w, {8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)});
        for (int i = 1; i <= 16; i++) send_byte(1, 8'(i));
        rx_valid[1] = 1'b1;
        rx_data[1]  = 8'd17;
        finish_load(1, 1, 4);
        ready_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_ready[1]) ready_seen++;
        end
        check("ready_after_full", ready_seen, 0);
        rx_valid[1] = 1'b0;

        check("sb_empty", sb0.size() + sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Sequential loader that writes a program image into instruction memory before the CPU runs. It takes a byte stream from the UART receiver, packs every four bytes into a 32-bit MIPS instruction word (most-significant byte first), and writes the words to consecutive instruction-memory word addresses starting at 0. While loading, it holds the CPU in a halted state, so the fetch/decode/control path only sees the new image after the load has finished.

## Interface
Parameters:
- ADDR_WIDTH, 14, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000, number of idle cycles (no byte accepted) that ends a load; legal range 2..2^20.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  a one-cycle pulse in IDLE begins a load; ignored in every other state.
- rx_valid  in  1  byte available from the UART receiver.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader can accept a byte; a byte is transferred when rx_valid and rx_ready are both high at a rising edge.
- imem_we  out  1  instruction-memory write enable, exactly one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  instruction word for the write.
- cpu_hold  out  1  high keeps the CPU halted and its PC at 0.
- done  out  1  one-cycle pulse when a load completes.
- word_count  out  ADDR_WIDTH+1  number of words written by the last load; held until the next start.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - rx_ready=0, cpu_hold=0.
  - start=1 → LOAD; clears the byte index, the address, word_count and the timeout counter.
- LOAD:
  - rx_ready=1, cpu_hold=1.
  - Each accepted byte shifts into the word register at byte position 3−index (byte 0 lands in bits [31:24]).
  - Each accepted byte resets the timeout counter and increments the index mod 4.
  - Acceptance of the 4th byte of a word → WRITE.
  - If no byte is accepted, the timeout counter increments each cycle. On reaching TIMEOUT_CYCLES−1:
    - partial word present (index≠0) → zero-fill the unreceived low bytes, then WRITE with the flush flag set;
    - otherwise → DONE.
- WRITE (one cycle):
  - imem_we=1, imem_addr=address, imem_wdata=word register, rx_ready=0, cpu_hold=1.
  - word_count, the address and the word register all update at the end of the cycle: word_count increments, the address increments, the word register clears.
  - Next state is DONE if the flush flag is set or the address was 2^ADDR_WIDTH−1 (memory full; further bytes are not accepted). Otherwise → LOAD with the timeout counter cleared.
- DONE (one cycle):
  - done=1, cpu_hold=1, rx_ready=0; → IDLE.
- rx_valid with rx_ready=0 is not consumed; the UART side holds the byte.
- Address arithmetic is ADDR_WIDTH bits and never wraps inside one load; a full load ends with word_count=2^ADDR_WIDTH.

## Timing
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, word_count=0; state IDLE.
- All outputs are registered or decoded from state only; none depends combinationally on rx_valid or start.
- start accepted at edge t → LOAD from t; rx_ready=1 and cpu_hold=1 in the cycle after edge t.
- 4th byte accepted at edge t → imem_we=1 for the cycle t..t+1 → rx_ready=1 again after edge t+1, unless the load is finishing.
- Sustained throughput: 4 bytes per 5 cycles.
- Last activity to done:
  - full-word end: timeout detected → done one cycle later;
  - partial-word end: timeout → WRITE → done.
- cpu_hold falls on the edge that leaves DONE, i.e. the cycle after done.
- rst_n low at any point (including mid-WRITE) returns all outputs to reset values immediately; the partial word is discarded.

## Test plan
- TIMEOUT_CYCLES=16. Reset, start, send 0x20,0x08,0x00,0x05,0x00,0x09,0x50,0x20 → writes 0x20080005@0 then 0x00095020@1, one imem_we cycle each; done after 16 idle cycles; word_count=2; cpu_hold low the cycle after done.
- Send 6 bytes AA,BB,CC,DD,11,22 then idle → writes 0xAABBCCDD@0 and 0x11220000@1 (zero-padded); word_count=2.
- Start then no bytes → done exactly 16 cycles after entering LOAD; imem_we never asserted; word_count=0.
- ADDR_WIDTH=2, stream 20 bytes back-to-back → writes addresses 0..3, done right after the 4th write without a timeout, rx_ready stays 0 for the remaining 4 bytes, word_count=4.
- rx_valid held high during WRITE → the byte is not consumed until rx_ready returns; a start pulse during LOAD has no effect.
- Assert rst_n=0 after 3 bytes of a word → all outputs at reset values with no write; a new start then loads again from address 0.
